// File: rtl/rmw_counter_bank_pkg.sv
// Shared definitions for the read-modify-write counter bank.
//   - FSM state encoding (CLEAR sweep / RUN)
//   - sat_add: wrap-or-clamp adder for operands up to SAT_MAX_W-1 bits
package rmw_counter_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Same encoding as the constants above, kept for waveform/debug tooling.
  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_e;

  // Widest counter the helper supports is SAT_MAX_W-1 bits.
  localparam int SAT_MAX_W = 64;

  // Adds a + b as a w-bit quantity (both operands must already fit in w bits).
  // Returns {clamped, value}: value is either the w-bit wrapped sum or, when
  // sat is set and the sum carried out of bit w-1, all-ones in w bits.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w,
    input logic                 sat
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] mask;
    logic               ovf;
    mask = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    sum  = {1'b0, a} + {1'b0, b};
    // Operands are below 2^w, so anything above bit w-1 is the single carry.
    ovf  = (sum >> w) != '0;
    if (sat && ovf) return {1'b1, mask[SAT_MAX_W-1:0]};
    sum = sum & mask;
    return {1'b0, sum[SAT_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/rmw_counter_bank_if.sv
// Request / update bus of the counter bank.
//   master: drives in_valid/in_addr/in_delta/clr_req, observes the rest
//   slave : the counter bank itself
interface rmw_counter_bank_if #(
  parameter int ADDR_W  = 3,
  parameter int DELTA_W = 8,
  parameter int DATA_W  = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_addr;
  logic [DELTA_W-1:0] in_delta;
  logic               clr_req;
  logic               busy;
  logic               upd_valid;
  logic [ADDR_W-1:0]  upd_addr;
  logic [DATA_W-1:0]  upd_value;
  logic               upd_sat;

  modport master (
    output in_valid, in_addr, in_delta, clr_req,
    input  in_ready, busy, upd_valid, upd_addr, upd_value, upd_sat
  );

  modport slave (
    input  in_valid, in_addr, in_delta, clr_req,
    output in_ready, busy, upd_valid, upd_addr, upd_value, upd_sat
  );
endinterface

// File: rtl/rmw_counter_mem.sv
// DEPTH x DATA_W counter storage: one synchronous read port (returns the
// pre-write contents on an address collision), one write port, no reset.
//   clk   : clock
//   we    : write enable, waddr/wdata: write port
//   raddr : read address, rdata registered one cycle later
module rmw_counter_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rmw_counter_bank.sv
// Pipelined read-modify-write counter bank. Each accepted request adds a
// zero-extended delta to one counter; the post-update value is reported two
// cycles after acceptance. Back-to-back hits on one counter are forwarded.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_addr/in_delta request, clr_req sweep
//                  trigger, busy, upd_valid/upd_addr/upd_value/upd_sat report
// DATA_W must be below 64; DELTA_W <= DATA_W; DEPTH a power of two >= 2.
module rmw_counter_bank
  import rmw_counter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int DELTA_W  = 8,
  parameter int SATURATE = 0
) (
  input logic               clk,
  input logic               reset_n,
  rmw_counter_bank_if.slave bus
);
  logic [0:0]         state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               accept;

  logic               s1_vld;
  logic [ADDR_W-1:0]  s1_addr;
  logic [DELTA_W-1:0] s1_delta;
  logic               fwd_q;
  logic [DATA_W-1:0]  fwd_val_q;
  logic [DATA_W-1:0]  mem_rd;
  logic [DATA_W-1:0]  operand;
  logic [SAT_MAX_W:0] sa;
  logic [SAT_MAX_W-1:DATA_W] sa_unused;
  logic [DATA_W-1:0]  s1_new;
  logic               s1_sat;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  assign bus.busy     = (state_q == ST_CLEAR);
  assign bus.in_ready = (state_q == ST_RUN) && !bus.clr_req;
  assign accept       = bus.in_valid && bus.in_ready;

  // Sweep FSM: DEPTH cycles of zero-writes, then RUN until the next clr_req.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (idx_q == ADDR_W'(DEPTH-1)) state_q <= ST_RUN;
      idx_q <= idx_q + 1'b1;
    end else if (bus.clr_req) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end
  end

  // S0 -> S1. The array read returns pre-write data, so when S1 is writing
  // the address being accepted, its result is captured here and selected
  // in place of the array output next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_addr   <= '0;
      s1_delta  <= '0;
      fwd_q     <= 1'b0;
      fwd_val_q <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_addr   <= bus.in_addr;
        s1_delta  <= bus.in_delta;
        fwd_q     <= s1_vld && (s1_addr == bus.in_addr);
        fwd_val_q <= s1_new;
      end
    end
  end

  assign operand   = fwd_q ? fwd_val_q : mem_rd;
  assign sa        = sat_add(SAT_MAX_W'(operand), SAT_MAX_W'(s1_delta),
                             DATA_W, SATURATE != 0);
  assign s1_new    = sa[DATA_W-1:0];
  assign s1_sat    = sa[SAT_MAX_W];
  assign sa_unused = sa[SAT_MAX_W-1:DATA_W];

  // The sweep owns the write port. An S1 write landing in the first CLEAR
  // cycle is dropped; the sweep zeroes that entry anyway, and the update is
  // still reported below.
  assign mem_we    = bus.busy || s1_vld;
  assign mem_waddr = bus.busy ? idx_q : s1_addr;
  assign mem_wdata = bus.busy ? '0 : s1_new;

  rmw_counter_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.in_addr),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.upd_valid <= 1'b0;
      bus.upd_addr  <= '0;
      bus.upd_value <= '0;
      bus.upd_sat   <= 1'b0;
    end else begin
      bus.upd_valid <= s1_vld;
      if (s1_vld) begin
        bus.upd_addr  <= s1_addr;
        bus.upd_value <= s1_new;
        bus.upd_sat   <= s1_sat;
      end
    end
  end
endmodule

// File: tb/tb_rmw_counter_bank.sv
// Drives three counter banks with identical stimulus (32-bit wrap, 8-bit
// wrap, 8-bit saturating) and checks them against an array/queue model.
module tb_rmw_counter_bank;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_req = 1'b0;
  logic [2:0] in_addr = '0;
  logic [7:0] in_delta = '0;

  always #5 clk = ~clk;

  rmw_counter_bank_if #(.ADDR_W(3), .DELTA_W(8), .DATA_W(32)) b32 ();
  rmw_counter_bank_if #(.ADDR_W(3), .DELTA_W(8), .DATA_W(8))  b8w ();
  rmw_counter_bank_if #(.ADDR_W(3), .DELTA_W(8), .DATA_W(8))  b8s ();

  assign b32.in_valid = in_valid; assign b32.clr_req = clr_req;
  assign b32.in_addr  = in_addr;  assign b32.in_delta = in_delta;
  assign b8w.in_valid = in_valid; assign b8w.clr_req = clr_req;
  assign b8w.in_addr  = in_addr;  assign b8w.in_delta = in_delta;
  assign b8s.in_valid = in_valid; assign b8s.clr_req = clr_req;
  assign b8s.in_addr  = in_addr;  assign b8s.in_delta = in_delta;

  rmw_counter_bank #(.DATA_W(32), .DEPTH(DEPTH), .DELTA_W(8), .SATURATE(0))
    u_d32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  rmw_counter_bank #(.DATA_W(8), .DEPTH(DEPTH), .DELTA_W(8), .SATURATE(0))
    u_d8w (.clk(clk), .reset_n(reset_n), .bus(b8w));
  rmw_counter_bank #(.DATA_W(8), .DEPTH(DEPTH), .DELTA_W(8), .SATURATE(1))
    u_d8s (.clk(clk), .reset_n(reset_n), .bus(b8s));

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [2:0] a;
    logic [31:0] v32;
    logic [7:0] v8w;
    logic [7:0] v8s;
    bit         s8s;
  } exp_t;

  longint unsigned m32 [DEPTH];
  int              m8w [DEPTH];
  int              m8s [DEPTH];
  int              clr_cnt;
  int              cyc = 0;
  exp_t            q [$];
  longint          obs32 [$];
  int              obs8w [$];
  int              obs8s [$];
  bit              obs_s8s [$];
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      m32[i] = 0; m8w[i] = 0; m8s[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [2:0] a, input logic [7:0] d);
    exp_t   e;
    int     s;
    m32[a] = (m32[a] + d) % 64'h1_0000_0000;
    m8w[a] = (m8w[a] + d) % 256;
    s = m8s[a] + d;
    e.s8s  = s > 255;
    m8s[a] = e.s8s ? 255 : s;
    e.due = cyc + 1;
    e.a   = a;
    e.v32 = m32[a][31:0];
    e.v8w = 8'(m8w[a]);
    e.v8s = 8'(m8s[a]);
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    bit   ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("upd_valid", {b32.upd_valid, b8w.upd_valid, b8s.upd_valid}, {3{ev}});
    check("busy", {b32.busy, b8w.busy, b8s.busy}, {3{clr_cnt > 0}});
    if (ev) begin
      e = q.pop_front();
      check("upd_addr", {b32.upd_addr, b8w.upd_addr, b8s.upd_addr}, {3{e.a}});
      check("upd_value32", b32.upd_value, e.v32);
      check("upd_value8w", b8w.upd_value, e.v8w);
      check("upd_value8s", b8s.upd_value, e.v8s);
      check("upd_sat", {b32.upd_sat, b8w.upd_sat, b8s.upd_sat}, {2'b00, e.s8s});
    end
    if (b32.upd_valid) obs32.push_back(b32.upd_value);
    if (b8w.upd_valid) obs8w.push_back(b8w.upd_value);
    if (b8s.upd_valid) begin
      obs8s.push_back(b8s.upd_value);
      obs_s8s.push_back(b8s.upd_sat);
    end
  endtask

  // One clock: drive in the low phase, check ready, update model at the
  // rising edge, check outputs at the falling edge.
  task automatic step(input bit v, input bit clr, input logic [2:0] a, input logic [7:0] d);
    bit rdy;
    in_valid = v; clr_req = clr; in_addr = a; in_delta = d;
    #1;
    rdy = (clr_cnt == 0) && !clr;
    check("in_ready", {b32.in_ready, b8w.in_ready, b8s.in_ready}, {3{rdy}});
    @(posedge clk);
    cyc++;
    if (clr_cnt > 0) clr_cnt--;
    else if (clr) begin
      model_zero();
      clr_cnt = DEPTH;
    end else if (v) model_apply(a, d);
    @(negedge clk);
    compare();
  endtask

  task automatic clear_obs();
    obs32.delete(); obs8w.delete(); obs8s.delete(); obs_s8s.delete();
  endtask

  // Hold reset for two cycles, checking reset values, then release in the
  // low phase so the next rising edge is the first sweep write.
  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; clr_req = 1'b0;
    q.delete();
    model_zero();
    clr_cnt = DEPTH;
    repeat (2) begin
      @(negedge clk);
      cyc++;
      check("rst_upd_valid", {b32.upd_valid, b8w.upd_valid, b8s.upd_valid}, 0);
      check("rst_in_ready", {b32.in_ready, b8w.in_ready, b8s.in_ready}, 0);
      check("rst_busy", {b32.busy, b8w.busy, b8s.busy}, 3'b111);
      check("rst_upd_value", b32.upd_value, 0);
      check("rst_upd_addr_sat", {b32.upd_addr, b32.upd_sat}, 0);
    end
    reset_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    longint     e32;
    int         e8w;
    int         e8s;
    bit         s8s;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{3'd3, 8'd1,   1,   1,   1,   1'b0};
    tbl[1]  = '{3'd5, 8'd1,   1,   1,   1,   1'b0};
    tbl[2]  = '{3'd5, 8'd2,   3,   3,   3,   1'b0};
    tbl[3]  = '{3'd5, 8'd3,   6,   6,   6,   1'b0};
    tbl[4]  = '{3'd0, 8'd4,   4,   4,   4,   1'b0};
    tbl[5]  = '{3'd1, 8'd4,   4,   4,   4,   1'b0};
    tbl[6]  = '{3'd0, 8'd4,   8,   8,   8,   1'b0};
    tbl[7]  = '{3'd1, 8'd4,   8,   8,   8,   1'b0};
    tbl[8]  = '{3'd0, 8'd4,   12,  12,  12,  1'b0};
    tbl[9]  = '{3'd1, 8'd4,   12,  12,  12,  1'b0};
    tbl[10] = '{3'd2, 8'd250, 250, 250, 250, 1'b0};
    tbl[11] = '{3'd2, 8'd10,  260, 4,   255, 1'b1};
    tbl[12] = '{3'd2, 8'd1,   261, 5,   255, 1'b1};

    do_reset();
    repeat (DEPTH) step(0, 0, 0, 0);

    // Back-to-back stream: single hit, same-address forwarding, alternating
    // addresses, then wrap/saturation on the 8-bit banks.
    clear_obs();
    for (int i = 0; i < 13; i++) step(1, 0, tbl[i].a, tbl[i].d);
    repeat (2) step(0, 0, 0, 0);
    check("tbl_count", obs32.size(), 13);
    for (int i = 0; i < 13 && i < obs32.size() && i < obs8s.size(); i++) begin
      check("tbl_v32", obs32[i], tbl[i].e32);
      check("tbl_v8w", obs8w[i], tbl[i].e8w);
      check("tbl_v8s", obs8s[i], tbl[i].e8s);
      check("tbl_s8s", obs_s8s[i], tbl[i].s8s);
    end

    // Clear while streaming: the in-flight update is still reported, the
    // sweep blocks requests for DEPTH cycles, the counter restarts at 0.
    clear_obs();
    step(1, 0, 3'd4, 8'd2);
    step(1, 1, 3'd6, 8'd1);
    repeat (DEPTH) step(1, 0, 3'd6, 8'd1);
    step(1, 0, 3'd4, 8'd7);
    repeat (2) step(0, 0, 0, 0);
    check("clr_count", obs32.size(), 2);
    if (obs32.size() == 2) begin
      check("clr_inflight", obs32[0], 2);
      check("clr_after", obs32[1], 7);
    end

    // Reset with a request sitting in S1: it must vanish, sweep restarts.
    clear_obs();
    step(1, 0, 3'd1, 8'd3);
    do_reset();
    repeat (DEPTH) step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 8'(i + 1));
    repeat (2) step(0, 0, 0, 0);
    check("rst_count", obs32.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < obs32.size(); i++)
      check("rst_fresh", obs32[i], i + 1);

    // Random traffic with occasional clears and large deltas.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
           3'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                       : 8'($urandom_range(0, 15)));
    end
    repeat (3) step(0, 0, 0, 0);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
